// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, the NOP word and
// the load-use detection rule.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_BAD   = 2'd3
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return mem_read && (rd != 5'd0) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one-cycle load-use stall and taken-branch flush,
// with saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             exmem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      lu;
  logic      stall_inc;
  logic      flush_inc;

  assign lu = load_use(idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2);

  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!reset) begin
      // Hold the front end and push bubbles down the pipe while in reset.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (exmem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      flush_inc   = 1'b1;
      state_d     = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = ST_STALL;
          end
        end
        // STALL and FLUSH ignore LU: ID/EX holds a bubble or IF/ID a NOP.
        ST_STALL: state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with CNT_W=4 covers saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs2;
  logic        exmem_branch_taken;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [31:0] stall_count, flush_count;
  logic [1:0]  state;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush;
  logic [3:0]  s_stall_count, s_flush_count;
  logic [1:0]  s_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .exmem_branch_taken(exmem_branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .stall_count(stall_count),
    .flush_count(flush_count), .state(state)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .exmem_branch_taken(exmem_branch_taken), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .exmem_flush(s_exmem_flush), .stall_count(s_stall_count),
    .flush_count(s_flush_count), .state(s_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_mem_read      = 1'b0;
    idex_rd            = 5'd0;
    ifid_rs1           = 5'd0;
    ifid_rs2           = 5'd0;
    ifid_uses_rs2      = 1'b0;
    exmem_branch_taken = 1'b0;
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic uses2);
    idex_mem_read = 1'b1;
    idex_rd       = rd;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
    ifid_uses_rs2 = uses2;
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00011",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d stall=%0d flush=%0d expected 0 0 0",
               state, stall_count, flush_count);
    end
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b11000) begin
      errors++;
      $display("FAIL run_idle_outputs: got %b expected 11000",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL lu_stall_outputs: got %b expected 001", {pc_write, ifid_write, idex_bubble});
    end
    step();
    checks++;
    if (state !== 2'd1 || stall_count !== 32'd1) begin
      errors++;
      $display("FAIL lu_enter_stall: state=%0d stall=%0d expected 1 1", state, stall_count);
    end
    // LU still present but must be ignored in STALL.
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
      errors++;
      $display("FAIL stall_outputs: got %b expected 110", {pc_write, ifid_write, idex_bubble});
    end
    step();
    checks++;
    if (state !== 2'd0 || stall_count !== 32'd1) begin
      errors++;
      $display("FAIL lu_back_to_run: state=%0d stall=%0d expected 0 1", state, stall_count);
    end
    idle();
    $display("test_load_use done");
  endtask

  task automatic test_no_hazard();
    apply_reset();
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_stall: pc_write=%b bubble=%b expected 1 0", pc_write, idex_bubble);
    end
    step();
    set_load(5'd7, 5'd3, 5'd7, 1'b0);
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL rs2_unused_no_stall: pc_write=%b bubble=%b expected 1 0", pc_write, idex_bubble);
    end
    step();
    checks++;
    if (state !== 2'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL no_hazard_count: state=%0d stall=%0d expected 0 0", state, stall_count);
    end
    set_load(5'd7, 5'd3, 5'd7, 1'b1);
    checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL rs2_used_stall: pc_write=%b bubble=%b expected 0 1", pc_write, idex_bubble);
    end
    step();
    idle();
    step();
    $display("test_no_hazard done");
  endtask

  task automatic test_branch_priority();
    apply_reset();
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    exmem_branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b11111) begin
      errors++;
      $display("FAIL branch_over_lu_outputs: got %b expected 11111",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    end
    step();
    checks++;
    if (state !== 2'd2 || flush_count !== 32'd1 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL branch_over_lu_state: state=%0d flush=%0d stall=%0d expected 2 1 0",
               state, flush_count, stall_count);
    end
    idle();
    step();
    $display("test_branch_priority done");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    exmem_branch_taken = 1'b1;
    #1;
    step();
    checks++;
    if (state !== 2'd2 || {ifid_flush, idex_bubble, exmem_flush} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_second_flush: state=%0d flush_outs=%b expected 2 111",
               state, {ifid_flush, idex_bubble, exmem_flush});
    end
    step();
    exmem_branch_taken = 1'b0;
    set_load(5'd9, 5'd9, 5'd0, 1'b0);
    checks++;
    if (state !== 2'd2 || flush_count !== 32'd2) begin
      errors++;
      $display("FAIL b2b_count: state=%0d flush=%0d expected 2 2", state, flush_count);
    end
    // LU ignored in FLUSH.
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush} !== 5'b11000) begin
      errors++;
      $display("FAIL flush_state_outputs: got %b expected 11000",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush});
    end
    step();
    checks++;
    if (state !== 2'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL flush_to_run: state=%0d stall=%0d expected 0 0", state, stall_count);
    end
    idle();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_load(5'd5, 5'd5, 5'd0, 1'b0);
    step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL mid_stall_entry: state=%0d expected 1", state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_reset_outputs: pc_write=%b bubble=%b expected 0 1",
               pc_write, idex_bubble);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_stall_reset_state: state=%0d stall=%0d flush=%0d expected 0 0 0",
               state, stall_count, flush_count);
    end
    idle();
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      set_load(5'd5, 5'd5, 5'd0, 1'b0);
      step();
      step();
      if (i == 15) begin
        checks++;
        if (s_stall_count !== 4'hF) begin
          errors++;
          $display("FAIL sat_at_15: got %h expected f", s_stall_count);
        end
      end
    end
    checks++;
    if (s_stall_count !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected f", s_stall_count);
    end
    checks++;
    if (stall_count !== 32'd17) begin
      errors++;
      $display("FAIL wide_count_17: got %0d expected 17", stall_count);
    end
    idle();
    $display("test_saturation done");
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_priority();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the stall and flush event counters.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 idex_mem_read  in  1  instruction currently in ID/EX is a load.
REQ-005 idex_rd  in  5  destination register of the ID/EX instruction.
REQ-006 ifid_rs1  in  5  rs1 field of the IF/ID instruction.
REQ-007 ifid_rs2  in  5  rs2 field of the IF/ID instruction.
REQ-008 ifid_uses_rs2  in  1  IF/ID instruction reads rs2 (R/S/B type).
REQ-009 exmem_branch_taken  in  1  branch resolved taken in the MEM stage this cycle.
REQ-010 pc_write  out  1  PC update enable.
REQ-011 ifid_write  out  1  IF/ID register load enable.
REQ-012 ifid_flush  out  1  IF/ID is loaded with a NOP.
REQ-013 idex_bubble  out  1  ID/EX control bits (Branch, MemRead, MemtoReg, MemWrite, RegWrite) are loaded as 0.
REQ-014 exmem_flush  out  1  EX/MEM control bits are loaded as 0.
REQ-015 stall_count  out  CNT_W  number of load-use stall cycles since reset.
REQ-016 flush_count  out  CNT_W  number of taken-branch flush events since reset.
REQ-017 state  out  2  FSM state (RUN=0, STALL=1, FLUSH=2).

Function
REQ-018 Load-use hazard (LU) SHALL be: idex_mem_read=1, idex_rd!=0, and (idex_rd==ifid_rs1 or (ifid_uses_rs2=1 and idex_rd==ifid_rs2)).
REQ-019 Outputs SHALL be combinational from state and inputs; state and counters SHALL be registered.
REQ-020 RUN, no event: pc_write=1, ifid_write=1, all flush/bubble outputs 0; next state RUN.
REQ-021 RUN with LU and exmem_branch_taken=0: pc_write=0, ifid_write=0, idex_bubble=1 in the same cycle; next state STALL; stall_count increments.
REQ-022 STALL: pc_write=1, ifid_write=1; LU SHALL NOT be evaluated (a bubble now occupies ID/EX); next state RUN. Each load SHALL therefore cost exactly one stall cycle.
REQ-023 exmem_branch_taken=1 in any state: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1, ifid_write=1; next state FLUSH; flush_count increments.
REQ-024 A taken branch SHALL take priority over LU in the same cycle: no stall, stall_count unchanged.
REQ-025 FLUSH: pc_write=1, ifid_write=1, no flush outputs; LU SHALL NOT be evaluated (IF/ID holds a NOP); next state RUN unless exmem_branch_taken=1 (REQ-023 applies).
REQ-026 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 Encoding 3 of state is unreachable; if it is entered, next state SHALL be RUN and outputs SHALL be as in RUN without LU.

Reset
REQ-028 While reset=0 at a rising edge: state<=RUN, stall_count<=0, flush_count<=0.
REQ-029 While reset=0: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, exmem_flush=1, so pipeline registers fill with bubbles.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the operation; the first cycle after release SHALL be RUN.

Structure
REQ-031 State encodings (RUN/STALL/FLUSH) and the NOP encoding 32'h00000013 SHALL live in a shared pipeline package used by all stage registers.
REQ-032 A sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc) SHALL be instantiated twice; everything else stays flat.

Verification
REQ-033 Load x5 in ID/EX, IF/ID has rs1=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; then RUN; stall_count=1.
REQ-034 Load x0 in ID/EX, rs1=0 -> no stall; stall_count=0. Load x7 with rs2=7 and ifid_uses_rs2=0 -> no stall.
REQ-035 LU and exmem_branch_taken together -> flush outputs all 1, pc_write=1, state FLUSH, flush_count=1, stall_count=0.
REQ-036 Taken branch on two consecutive cycles -> flush outputs 1 on both cycles; flush_count=2; state FLUSH, then RUN.
REQ-037 reset=0 while in STALL -> next cycle state=0 and counters 0; during reset pc_write=0 and idex_bubble=1.
REQ-038 CNT_W=4: 17 stall events -> stall_count holds 4'hF.
